// File: rtl/if_stage.sv
// Instruction fetch stage: one-outstanding-request fetch FSM with a skid
// buffer for stalled responses and redirect handling for branches/jumps.
module if_stage #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  branchN,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [DATA_WIDTH-1:0] jump_target,
    input  logic                  stall,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_valid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] if_id_pc,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic                  if_id_valid
);

    localparam logic [DATA_WIDTH-1:0] NOP      = DATA_WIDTH'(32'h0000_0013);
    localparam logic [DATA_WIDTH-1:0] PC_INCR  = DATA_WIDTH'(4);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] pc, pc_d;
    logic                  req_d;
    logic [DATA_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] skid_pc, skid_pc_d;
    logic [DATA_WIDTH-1:0] skid_instr, skid_instr_d;
    logic [DATA_WIDTH-1:0] if_id_pc_d, if_id_instr_d;
    logic                  if_id_valid_d;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] target;

    function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] a);
        return {a[DATA_WIDTH-1:2], 2'b00};
    endfunction

    assign redirect = branchN | jump;
    assign target   = branchN ? branch_target : jump_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_d;
    end

    // Next state and next register values; imem_addr doubles as the pending
    // address while a discarded response is still in flight.
    always_comb begin
        state_d       = state;
        pc_d          = pc;
        skid_pc_d     = skid_pc;
        skid_instr_d  = skid_instr;
        if_id_pc_d    = if_id_pc;
        if_id_instr_d = if_id_instr;
        if_id_valid_d = if_id_valid;
        req_d         = imem_req;
        addr_d        = imem_addr;

        case (state)
            FETCH: begin
                if (imem_req && imem_valid) begin
                    if (redirect) begin
                        pc_d = target;
                    end else if (stall) begin
                        skid_pc_d    = pc;
                        skid_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end else begin
                        if_id_pc_d    = pc;
                        if_id_instr_d = imem_rdata;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc + PC_INCR;
                    end
                end else if (redirect) begin
                    pc_d = target;
                    if (imem_req) state_d = DRAIN;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!stall) begin
                    if_id_pc_d    = skid_pc;
                    if_id_instr_d = skid_instr;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc + PC_INCR;
                    state_d       = FETCH;
                end
            end
            DRAIN: begin
                if (redirect)   pc_d    = target;
                if (imem_valid) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        if (redirect) begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NOP;
        end

        req_d  = (state_d != HOLD);
        addr_d = (state_d == DRAIN) ? imem_addr : word_align(pc_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= word_align(RESET_PC);
            skid_pc     <= '0;
            skid_instr  <= '0;
            if_id_pc    <= '0;
            if_id_instr <= NOP;
            if_id_valid <= 1'b0;
        end else begin
            pc          <= pc_d;
            imem_req    <= req_d;
            imem_addr   <= addr_d;
            skid_pc     <= skid_pc_d;
            skid_instr  <= skid_instr_d;
            if_id_pc    <= if_id_pc_d;
            if_id_instr <= if_id_instr_d;
            if_id_valid <= if_id_valid_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic against a
// transaction-level fetch model checked every falling edge.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, rst;
    logic        branchN, jump, stall;
    logic [31:0] branch_target, jump_target;
    logic        imem_req, imem_valid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] if_id_pc, if_id_instr;
    logic        if_id_valid;

    int checks   = 0;
    int failures = 0;

    // memory responder state (driver side)
    logic [31:0] key;
    int          fix_lat;
    logic        mbusy;
    int          mlat;
    logic [31:0] maddr;

    // reference model state (compare side)
    logic [31:0] m_pc, m_old_addr, m_skid_pc, m_skid_instr;
    logic [31:0] m_ifid_pc, m_ifid_instr;
    logic        m_started, m_discard, m_skid_full, m_ifid_valid;

    if_stage dut (
        .clk(clk), .rst(rst),
        .branchN(branchN), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] al(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_started = 1'b0; m_discard = 1'b0; m_old_addr = 32'h0;
        m_skid_full = 1'b0; m_skid_pc = 32'h0; m_skid_instr = 32'h0;
        m_ifid_pc = 32'h0; m_ifid_instr = NOP; m_ifid_valid = 1'b0;
    endtask

    // Advance the model by one clock using this cycle's inputs.
    task automatic model_step();
        logic        redir;
        logic [31:0] tgt;
        redir = branchN | jump;
        tgt   = branchN ? branch_target : jump_target;
        if (!m_started) begin
            m_started = 1'b1;
            if (redir) m_pc = tgt;
        end else if (m_skid_full) begin
            if (redir) begin
                m_skid_full = 1'b0; m_pc = tgt;
            end else if (!stall) begin
                m_ifid_pc = m_skid_pc; m_ifid_instr = m_skid_instr; m_ifid_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_skid_full = 1'b0;
            end
        end else if (m_discard) begin
            if (redir) m_pc = tgt;
            if (imem_valid) m_discard = 1'b0;
        end else if (imem_valid) begin
            if (redir) m_pc = tgt;
            else if (stall) begin
                m_skid_pc = m_pc; m_skid_instr = al(m_pc) ^ key; m_skid_full = 1'b1;
            end else begin
                m_ifid_pc = m_pc; m_ifid_instr = al(m_pc) ^ key; m_ifid_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end else if (redir) begin
            m_old_addr = al(m_pc); m_pc = tgt; m_discard = 1'b1;
        end
        if (redir) begin
            m_ifid_valid = 1'b0; m_ifid_instr = NOP;
        end
    endtask

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (rst) model_reset();
        chk("imem_req", {31'h0, imem_req}, {31'h0, m_started && !m_skid_full});
        if (m_started && !m_skid_full)
            chk("imem_addr", imem_addr, m_discard ? m_old_addr : al(m_pc));
        chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_ifid_valid});
        chk("if_id_instr", if_id_instr, m_ifid_instr);
        if (m_ifid_valid) chk("if_id_pc", if_id_pc, m_ifid_pc);
        if (!rst) model_step();
    end

    // One clock: drive controls, answer memory, advance to posedge+1.
    task automatic cycle(input logic br, input logic [31:0] bt, input logic jp,
                         input logic [31:0] jt, input logic st);
        branchN = br; branch_target = bt; jump = jp; jump_target = jt; stall = st;
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        if (!mbusy && imem_req) begin
            mbusy = 1'b1;
            mlat  = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 2));
            maddr = imem_addr;
        end
        if (mbusy) begin
            if (mlat == 0) begin
                imem_valid = 1'b1; imem_rdata = maddr ^ key; mbusy = 1'b0;
            end else begin
                mlat--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset(input logic [31:0] k);
        rst = 1'b1; mbusy = 1'b0; key = k; fix_lat = 0;
        branchN = 1'b0; jump = 1'b0; stall = 1'b0; imem_valid = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0; imem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_pc", if_id_pc, 32'h0);
        rst = 1'b0;
        idle();
    endtask

    task automatic run_to(input logic [31:0] a);
        int n = 0;
        while (imem_addr !== a || imem_req !== 1'b1) begin
            if (n >= 200) begin
                checks++; failures++;
                $display("FAIL run_to timeout: addr %h never reached, at %h", a, imem_addr);
                return;
            end
            idle();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        do_reset(32'h0);

        // zero-wait sequential fetch, data == address
        chk("first_addr", imem_addr, 32'h0);
        chk("first_req", {31'h0, imem_req}, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            idle();
            chk("seq_addr", imem_addr, 32'(4 * k));
            chk("seq_pc", if_id_pc, 32'(4 * (k - 1)));
            chk("seq_instr", if_id_instr, 32'(4 * (k - 1)));
            chk("seq_valid", {31'h0, if_id_valid}, 32'h1);
        end

        // stall for three cycles while the response for 0x8 arrives
        do_reset(32'h0);
        run_to(32'h8);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("hold_req", {31'h0, imem_req}, 32'h0);
        chk("hold_pc", if_id_pc, 32'h4);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("hold_req2", {31'h0, imem_req}, 32'h0);
        chk("hold_pc2", if_id_pc, 32'h4);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        idle();
        chk("unstall_pc", if_id_pc, 32'h8);
        chk("unstall_valid", {31'h0, if_id_valid}, 32'h1);
        chk("unstall_addr", imem_addr, 32'hC);

        // branch coinciding with the response for 0x10
        do_reset(32'h0);
        run_to(32'h10);
        cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        chk("br_valid", {31'h0, if_id_valid}, 32'h0);
        chk("br_instr", if_id_instr, NOP);
        chk("br_addr", imem_addr, 32'h100);

        // jump while a slow response for 0x20 is outstanding
        do_reset(32'h0);
        run_to(32'h20);
        fix_lat = 2;
        cycle(1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
        chk("drain_addr1", imem_addr, 32'h20);
        chk("drain_req1", {31'h0, imem_req}, 32'h1);
        idle();
        chk("drain_addr2", imem_addr, 32'h20);
        idle();
        chk("drain_done_addr", imem_addr, 32'h200);
        chk("drain_valid", {31'h0, if_id_valid}, 32'h0);
        fix_lat = 0;
        idle();
        chk("after_drain_pc", if_id_pc, 32'h200);

        // simultaneous branch and jump: branch wins
        do_reset(32'h0);
        run_to(32'h10);
        cycle(1'b1, 32'h40, 1'b1, 32'h80, 1'b0);
        chk("prio_addr", imem_addr, 32'h40);

        // PC wrap at the top of the address space
        do_reset(32'h0);
        run_to(32'h10);
        cycle(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
        idle();
        chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_addr", imem_addr, 32'h0);

        // unaligned target: address masked, PC kept as given
        do_reset(32'h0);
        run_to(32'h8);
        cycle(1'b0, 32'h0, 1'b1, 32'h203, 1'b0);
        chk("unal_addr", imem_addr, 32'h200);
        idle();
        chk("unal_pc", if_id_pc, 32'h203);
        chk("unal_next", imem_addr, 32'h204);

        // randomized traffic
        do_reset(32'h5A3C_0000);
        fix_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] bt, jt;
            bt = $urandom;
            jt = $urandom;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
            cycle($urandom_range(0, 9) == 0, bt, $urandom_range(0, 9) == 0, jt,
                  $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
